engine_arbiter: RTL and testbench
=================================

ENGINE_ARBITER -- requirements
Module: engine_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters sharing one streaming engine.
REQ-002 The block SHALL have parameter DW, default 32, data word width.
REQ-003 The block SHALL have parameter TMO, default 1024, max cycles in DRAIN before abort.
REQ-004 The block SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port req  input  NREQ  per-requester job request, held high for the whole input phase of a job.
REQ-007 The block SHALL have port req_din  input  NREQ*DW  per-requester data, slice i = bits [i*DW +: DW].
REQ-008 The block SHALL have port req_wen  input  NREQ  per-requester write strobe.
REQ-009 The block SHALL have port req_rdy  output  NREQ  per-requester ready; only the granted bit may be high.
REQ-010 The block SHALL have port gnt  output  NREQ  one-hot grant, zero when idle.
REQ-011 The block SHALL have port rsp_dout  output  DW  result word, valid with rsp_valid.
REQ-012 The block SHALL have port rsp_valid  output  NREQ  one-cycle per-requester result pulse.
REQ-013 The block SHALL have port eng_din  output  DW  engine data.
REQ-014 The block SHALL have port eng_wen  output  1  engine write strobe.
REQ-015 The block SHALL have port eng_rdy  input  1  engine can accept a word.
REQ-016 The block SHALL have port eng_dout  input  DW  engine result.
REQ-017 The block SHALL have port eng_done  input  1  engine job-complete pulse.
REQ-018 The block SHALL have port timeout_err  output  1  one-cycle pulse on DRAIN timeout.

Function
REQ-019 The FSM SHALL have states IDLE, BUSY, DRAIN, RESP.
REQ-020 IDLE: if any req bit high, the block SHALL register a one-hot round-robin winner into gnt and enter BUSY next cycle; otherwise stay IDLE.
REQ-021 Round-robin: search SHALL start at index (last_gnt+1) mod NREQ and wrap; after reset last_gnt = NREQ-1, so requester 0 has top priority.
REQ-022 BUSY: eng_din SHALL equal the granted req_din slice, eng_wen = granted req_wen AND eng_rdy, req_rdy[g] = eng_rdy; all combinational, zero added latency.
REQ-023 A word SHALL transfer only in a cycle where req_wen[g] and eng_rdy are both high; words with eng_rdy low SHALL NOT reach the engine.
REQ-024 BUSY: req[g] low SHALL move the FSM to DRAIN; eng_wen and req_rdy SHALL be 0 from DRAIN onward.
REQ-025 BUSY or DRAIN: eng_done high SHALL capture eng_dout into rsp_dout and enter RESP; eng_done has priority over req[g] falling in the same cycle.
REQ-026 RESP: rsp_valid[g] SHALL be 1 for exactly one cycle, then gnt clears, last_gnt = g, FSM returns to IDLE.
REQ-027 Minimum turnaround: next grant SHALL appear no earlier than the cycle after RESP (one IDLE cycle).
REQ-028 DRAIN: a counter SHALL count cycles from 0; at TMO-1 without eng_done the block SHALL pulse timeout_err, set no rsp_valid, update last_gnt, return to IDLE.
REQ-029 eng_done in IDLE SHALL be ignored.
REQ-030 Request changes of non-granted requesters SHALL NOT affect the current grant.
REQ-031 rsp_dout SHALL hold its last value until the next capture.

Reset
REQ-032 rst_n low SHALL immediately force: FSM IDLE, gnt 0, req_rdy 0, rsp_valid 0, rsp_dout 0, eng_wen 0, eng_din 0, timeout_err 0, counter 0, last_gnt NREQ-1.
REQ-033 Reset mid-job SHALL abandon the job with no rsp_valid; first grant after release follows REQ-021.

Verification
REQ-034 Single job: req[2] with 3 words 0x11,0x22,0x33, eng_rdy=1, then req low, eng_done with eng_dout=0xCAFE -> eng_din sees the 3 words in order, rsp_valid=4'b0100 for one cycle, rsp_dout=0xCAFE.
REQ-035 Contention: req=4'b1111 continuously after reset -> grants in order 0,1,2,3,0, each completing before the next.
REQ-036 Backpressure: eng_rdy toggles 1,0,1,0 while req_wen held high -> eng_wen high only when eng_rdy high, no words lost or duplicated.
REQ-037 Timeout: req[1] drops, eng_done never asserts, TMO=16 -> timeout_err pulses 16 cycles after DRAIN entry, no rsp_valid, next grant goes to requester 2 if requesting.
REQ-038 Reset in BUSY: rst_n low mid-transfer -> gnt and all outputs 0 asynchronously; after release req=4'b1000 is granted with gnt=4'b1000.

Source files
------------

// File: rtl/engine_arbiter.sv
// Round-robin arbiter that hands one shared streaming engine to NREQ requesters,
// one whole job at a time, with a drain timeout that aborts a job the engine never finishes.
module engine_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int TMO  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_din,
  input  logic [NREQ-1:0]   req_wen,
  output logic [NREQ-1:0]   req_rdy,
  output logic [NREQ-1:0]   gnt,
  output logic [DW-1:0]     rsp_dout,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     eng_din,
  output logic              eng_wen,
  input  logic              eng_rdy,
  input  logic [DW-1:0]     eng_dout,
  input  logic              eng_done,
  output logic              timeout_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [IW-1:0]   gidx, gidx_nxt;
  logic [IW-1:0]   last_gnt, last_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]   dout_nxt;
  logic            tmo_nxt;
  logic            win_any;
  logic [IW-1:0]   win_idx;
  logic [DW-1:0]   din_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign din_arr[i] = req_din[i*DW +: DW];
  end

  // Walk offsets from farthest to nearest so the nearest requester after last_gnt wins.
  always_comb begin
    int k;
    logic [IW-1:0] kk;
    win_any = 1'b0;
    win_idx = '0;
    k       = 0;
    kk      = '0;
    for (int i = NREQ; i >= 1; i--) begin
      k  = (int'(last_gnt) + i) % NREQ;
      kk = IW'(k);
      if (req[kk]) begin
        win_any = 1'b1;
        win_idx = kk;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    gidx_nxt  = gidx;
    last_nxt  = last_gnt;
    cnt_nxt   = '0;
    dout_nxt  = rsp_dout;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (win_any) begin
          gnt_nxt   = NREQ'(1) << win_idx;
          gidx_nxt  = win_idx;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (eng_done) begin
          dout_nxt  = eng_dout;
          state_nxt = RESP;
        end else if (!req[gidx]) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (eng_done) begin
          dout_nxt  = eng_dout;
          state_nxt = RESP;
        end else if (cnt == CW'(TMO - 1)) begin
          tmo_nxt   = 1'b1;
          gnt_nxt   = '0;
          last_nxt  = gidx;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RESP: begin
        gnt_nxt   = '0;
        last_nxt  = gidx;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      gidx        <= '0;
      last_gnt    <= IW'(NREQ - 1);
      cnt         <= '0;
      rsp_dout    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      gidx        <= gidx_nxt;
      last_gnt    <= last_nxt;
      cnt         <= cnt_nxt;
      rsp_dout    <= dout_nxt;
      timeout_err <= tmo_nxt;
    end
  end

  // Streaming path is purely combinational so the engine sees the requester with no added latency.
  assign eng_din   = (state == BUSY) ? din_arr[gidx] : '0;
  assign eng_wen   = (state == BUSY) && eng_rdy && req_wen[gidx];
  assign req_rdy   = (state == BUSY) ? (gnt & {NREQ{eng_rdy}}) : '0;
  assign rsp_valid = (state == RESP) ? gnt : '0;

endmodule

// File: tb/tb_engine_arbiter.sv
// Directed bench for engine_arbiter: engine words and responses are predicted into
// queues when driven and compared by negedge monitors when the DUT produces them.
module tb_engine_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int TMO  = 16;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_din;
  logic [NREQ-1:0]   req_wen;
  logic [NREQ-1:0]   req_rdy;
  logic [NREQ-1:0]   gnt;
  logic [DW-1:0]     rsp_dout;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     eng_din;
  logic              eng_wen;
  logic              eng_rdy;
  logic [DW-1:0]     eng_dout;
  logic              eng_done;
  logic              timeout_err;

  logic [DW-1:0]     din_arr [NREQ];
  logic [DW-1:0]     exp_w [$];
  logic [35:0]       exp_r [$];
  int                checks;
  int                errors;

  engine_arbiter #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_din(req_din), .req_wen(req_wen),
    .req_rdy(req_rdy), .gnt(gnt), .rsp_dout(rsp_dout), .rsp_valid(rsp_valid),
    .eng_din(eng_din), .eng_wen(eng_wen), .eng_rdy(eng_rdy), .eng_dout(eng_dout),
    .eng_done(eng_done), .timeout_err(timeout_err)
  );

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign req_din[i*DW +: DW] = din_arr[i];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input logic [NREQ-1:0] exp, input string tag);
    int n;
    n = 0;
    while (gnt === '0 && n < 10) begin
      cyc();
      n++;
    end
    chk(tag, 64'(gnt), 64'(exp));
  endtask

  // Engine-side monitor: every accepted word must be the next predicted one.
  always @(negedge clk) begin
    if (eng_wen === 1'b1) begin
      if (exp_w.size() == 0) chk("eng_word_unexpected", 64'(eng_din), 64'hFFFF_FFFF_FFFF);
      else chk("eng_word", 64'(eng_din), 64'(exp_w.pop_front()));
    end
  end

  // Response monitor: every rsp_valid pulse must match the next predicted response.
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (exp_r.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'h0);
      else chk("rsp", 64'({rsp_valid, rsp_dout}), 64'(exp_r.pop_front()));
    end
  end

  initial begin
    int n;
    logic [1:0] g;
    logic [DW-1:0] k;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    req      = '0;
    req_wen  = '0;
    eng_rdy  = 1'b0;
    eng_dout = '0;
    eng_done = 1'b0;
    for (int i = 0; i < NREQ; i++) din_arr[i] = '0;
    cyc();
    cyc();
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_outs", 64'({req_rdy, rsp_valid, eng_wen, timeout_err}), 64'h0);
    chk("rst_data", 64'({rsp_dout, eng_din}), 64'h0);
    rst_n = 1'b1;
    cyc();

    // Single job on requester 2
    req = 4'b0100;
    cyc();
    chk("single_gnt", 64'(gnt), 64'h4);
    eng_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_arr[2] = 32'h11 * (i + 1);
      req_wen    = 4'b0100;
      exp_w.push_back(32'h11 * (i + 1));
      cyc();
    end
    req_wen = '0;
    req     = '0;
    cyc();
    chk("drain_rdy", 64'({req_rdy, eng_wen}), 64'h0);
    eng_done = 1'b1;
    eng_dout = 32'hCAFE;
    exp_r.push_back({4'b0100, 32'hCAFE});
    cyc();
    eng_done = 1'b0;
    chk("single_rsp_valid", 64'(rsp_valid), 64'h4);
    cyc();
    chk("single_rsp_clear", 64'({gnt, rsp_valid}), 64'h0);
    chk("single_rsp_dout", 64'(rsp_dout), 64'hCAFE);

    // eng_done while idle must be ignored
    eng_done = 1'b1;
    eng_dout = 32'hDEAD;
    cyc();
    eng_done = 1'b0;
    cyc();
    chk("idle_done_gnt", 64'(gnt), 64'h0);
    chk("idle_done_hold", 64'(rsp_dout), 64'hCAFE);

    // Contention from a fresh reset: 0,1,2,3,0
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      g = 2'(j % 4);
      wait_gnt(4'b0001 << g, "rr_gnt");
      din_arr[g] = 32'h100 + 32'(j);
      req_wen    = 4'b0001 << g;
      exp_w.push_back(32'h100 + 32'(j));
      cyc();
      req_wen  = '0;
      eng_done = 1'b1;
      eng_dout = 32'h200 + 32'(j);
      exp_r.push_back({4'b0001 << g, 32'h200 + 32'(j)});
      cyc();
      eng_done = 1'b0;
      cyc();
      chk("rr_turnaround", 64'(gnt), 64'h0);
    end
    req = '0;
    cyc();

    // Backpressure on requester 1, then let it drain into a timeout
    req = 4'b0010;
    wait_gnt(4'b0010, "bp_gnt");
    k = 32'hA0;
    for (int c = 0; c < 6; c++) begin
      eng_rdy    = (c % 2 == 0);
      din_arr[1] = k;
      req_wen    = 4'b0010;
      if (eng_rdy) exp_w.push_back(k);
      #1;
      chk("bp_eng_wen", 64'(eng_wen), 64'(eng_rdy));
      chk("bp_req_rdy", 64'(req_rdy), 64'({2'b00, eng_rdy, 1'b0}));
      cyc();
      if (eng_rdy) k = k + 1;
    end
    req = 4'b0100;
    cyc();
    eng_rdy = 1'b1;
    #1;
    chk("drain_gnt_held", 64'(gnt), 64'h2);
    chk("drain_quiet", 64'({req_rdy, eng_wen}), 64'h0);
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk("tmo_latency", 64'(n), 64'(TMO));
    cyc();
    chk("tmo_pulse_once", 64'(timeout_err), 64'h0);
    chk("tmo_next_gnt", 64'(gnt), 64'h4);

    // Asynchronous reset in the middle of a transfer
    req_wen    = 4'b0100;
    din_arr[2] = 32'h77;
    exp_w.push_back(32'h77);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 64'(gnt), 64'h0);
    chk("arst_outs", 64'({req_rdy, rsp_valid, eng_wen, timeout_err}), 64'h0);
    chk("arst_data", 64'({rsp_dout, eng_din}), 64'h0);
    req     = 4'b1000;
    req_wen = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_gnt", 64'(gnt), 64'h8);

    // eng_done wins over req falling in the same cycle
    din_arr[3] = 32'h99;
    req_wen    = 4'b1000;
    exp_w.push_back(32'h99);
    cyc();
    req_wen  = '0;
    req      = '0;
    eng_done = 1'b1;
    eng_dout = 32'hBEEF;
    exp_r.push_back({4'b1000, 32'hBEEF});
    cyc();
    eng_done = 1'b0;
    cyc();
    chk("prio_gnt_clear", 64'(gnt), 64'h0);
    chk("prio_dout", 64'(rsp_dout), 64'hBEEF);

    cyc();
    chk("words_left", 64'(exp_w.size()), 64'h0);
    chk("rsps_left", 64'(exp_r.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
